// File: rtl/muxes_tx_pkg.sv
// Shared constants for the transmit 4:1 byte mux and its receive-side counterpart.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package muxes_tx_pkg;

  // Number of lanes folded onto the serial stream and the slot-counter width.
  localparam int LANES   = 4;
  localparam int PHASE_W = 2;

  // Default comma/idle character placed in invalid slots when idle fill is on.
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;

  typedef logic [PHASE_W-1:0] phase_t;

endpackage

// File: rtl/muxes_tx_lane_hold.sv
// One lane's holding register (data + valid), loaded once per frame.
// Latency: 1 cycle from cap_en edge to q/q_vld.
// Backpressure: none; loads whenever cap_en is high.
module mux_lane_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] d,
  input  logic              d_vld,
  output logic [DATA_W-1:0] q,
  output logic              q_vld
);

  // Capture lane byte and valid on the frame capture edge; sync clear on reset.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else if (cap_en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/muxes_tx.sv
// Transmit 4:1 byte mux: captures four lanes at phase 3, serialises lane 0..3 at 4x rate.
// Latency: lane k appears on Salida k+1 cycles after the capture edge.
// Backpressure: none; one slot is emitted every cycle unconditionally.
// Build option: define MUXES_TX_IDLE_FILL_EN to send IDLE_BYTE in invalid slots (else 8'h00).
module muxes_tx
  import muxes_tx_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
  input  logic               clk_4f,
  input  logic               reset,
  input  logic [DATA_W-1:0]  Entrada0,
  input  logic [DATA_W-1:0]  Entrada1,
  input  logic [DATA_W-1:0]  Entrada2,
  input  logic [DATA_W-1:0]  Entrada3,
  input  logic               validEntrada0,
  input  logic               validEntrada1,
  input  logic               validEntrada2,
  input  logic               validEntrada3,
  output logic [DATA_W-1:0]  Salida,
  output logic               validSalida,
  output logic               frame_start,
  output logic [PHASE_W-1:0] phase
);

`ifdef MUXES_TX_IDLE_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  // Byte driven in slots whose lane was captured invalid.
  localparam logic [DATA_W-1:0] FILL_BYTE = FILL_EN ? IDLE_BYTE : '0;

  logic [DATA_W-1:0] lane_dat [LANES];
  logic [LANES-1:0]  lane_vld;
  logic [DATA_W-1:0] hold     [LANES];
  logic [LANES-1:0]  hvld;
  logic              cap_en;
  logic [DATA_W-1:0] slot_dat;

  assign lane_dat[0] = Entrada0;
  assign lane_dat[1] = Entrada1;
  assign lane_dat[2] = Entrada2;
  assign lane_dat[3] = Entrada3;
  assign lane_vld    = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};

  // Upstream aligns its frame to the last slot, so the new frame loads while
  // lane 3 of the previous frame is leaving.
  assign cap_en = (phase == PHASE_W'(LANES - 1));

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mux_lane_hold #(.DATA_W(DATA_W)) u_hold (
      .clk_4f (clk_4f),
      .reset  (reset),
      .cap_en (cap_en),
      .d      (lane_dat[k]),
      .d_vld  (lane_vld[k]),
      .q      (hold[k]),
      .q_vld  (hvld[k])
    );
  end

  // Select the current slot's byte, substituting the fill byte for invalid lanes.
  always_comb begin
    slot_dat = FILL_BYTE;
    if (hvld[phase]) begin
      slot_dat = hold[phase];
    end
  end

  // Phase counter and registered serial output; holding registers are read
  // before this edge's capture takes effect.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      phase       <= '0;
      Salida      <= '0;
      validSalida <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      phase       <= phase + PHASE_W'(1);
      Salida      <= slot_dat;
      validSalida <= hvld[phase];
      frame_start <= (phase == '0);
    end
  end

endmodule

// File: tb/tb_muxes_tx.sv
// Bench for muxes_tx: fixed vector table plus randomized run against a slot-queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_muxes_tx;

`ifdef MUXES_TX_IDLE_FILL_EN
  localparam logic [7:0] FILL = 8'hBC;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] Entrada0 = '0, Entrada1 = '0, Entrada2 = '0, Entrada3 = '0;
  logic       validEntrada0 = 1'b0, validEntrada1 = 1'b0;
  logic       validEntrada2 = 1'b0, validEntrada3 = 1'b0;
  logic [7:0] Salida;
  logic       validSalida;
  logic       frame_start;
  logic [1:0] phase;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_4f = ~clk_4f;

  muxes_tx dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .Entrada0      (Entrada0),
    .Entrada1      (Entrada1),
    .Entrada2      (Entrada2),
    .Entrada3      (Entrada3),
    .validEntrada0 (validEntrada0),
    .validEntrada1 (validEntrada1),
    .validEntrada2 (validEntrada2),
    .validEntrada3 (validEntrada3),
    .Salida        (Salida),
    .validSalida   (validSalida),
    .frame_start   (frame_start),
    .phase         (phase)
  );

  // Table record: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst;
    logic [31:0] din;   // {lane3, lane2, lane1, lane0}
    logic [3:0]  vin;
    logic [7:0]  e_dat;
    logic        e_vld;
    logic        e_fs;
    logic [1:0]  e_ph;
  } vec_t;

  // Model: stream of expected output slots, refilled with a whole frame at
  // every fourth edge after reset.
  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       fs;
  } slot_t;

  vec_t  tbl[$];
  slot_t mq[$];
  int    mcnt = 0;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [31:0] d, logic [3:0] v);
    reset         = r;
    Entrada0      = d[7:0];
    Entrada1      = d[15:8];
    Entrada2      = d[23:16];
    Entrada3      = d[31:24];
    validEntrada0 = v[0];
    validEntrada1 = v[1];
    validEntrada2 = v[2];
    validEntrada3 = v[3];
  endtask

  // Append four table rows: inputs held for one frame, expected lane bytes.
  task automatic add_frame(logic [31:0] din, logic [3:0] vin,
                           logic [31:0] ed, logic [3:0] ev);
    vec_t r;
    for (int k = 0; k < 4; k++) begin
      r.rst   = 1'b0;
      r.din   = din;
      r.vin   = vin;
      r.e_dat = ed[8*k +: 8];
      r.e_vld = ev[k];
      r.e_fs  = (k == 0);
      r.e_ph  = 2'((k + 1) % 4);
      tbl.push_back(r);
    end
  endtask

  // Advance one edge with the currently driven inputs and check against the model.
  task automatic tick_model(string tag);
    slot_t       e;
    slot_t       s;
    logic [1:0]  eph;
    logic [31:0] din;
    logic [3:0]  vin;
    din = {Entrada3, Entrada2, Entrada1, Entrada0};
    vin = {validEntrada3, validEntrada2, validEntrada1, validEntrada0};
    if (reset) begin
      e = '{d: 8'h00, v: 1'b0, fs: 1'b0};
      mq.delete();
      for (int k = 0; k < 4; k++) begin
        s = '{d: FILL, v: 1'b0, fs: (k == 0)};
        mq.push_back(s);
      end
      mcnt = 0;
    end else begin
      e = mq.pop_front();
      mcnt++;
      if (mcnt % 4 == 0) begin
        for (int k = 0; k < 4; k++) begin
          s.d  = vin[k] ? din[8*k +: 8] : FILL;
          s.v  = vin[k];
          s.fs = (k == 0);
          mq.push_back(s);
        end
      end
    end
    eph = 2'(mcnt % 4);
    @(posedge clk_4f);
    #1;
    chk({tag, ".Salida"},      int'(Salida),      int'(e.d));
    chk({tag, ".validSalida"}, int'(validSalida), int'(e.v));
    chk({tag, ".frame_start"}, int'(frame_start), int'(e.fs));
    chk({tag, ".phase"},       int'(phase),       int'(eph));
  endtask

  initial begin
    vec_t r;
    logic [7:0] edat;

    // ---------------- table-driven directed sequence ----------------
    r = '{rst: 1'b1, din: '0, vin: '0, e_dat: '0, e_vld: 1'b0, e_fs: 1'b0, e_ph: '0};
    tbl.push_back(r);
    add_frame(32'h44332211, 4'hF,   32'h0,        4'h0);  // zeroed frame after reset
    add_frame(32'h44FF2211, 4'b1011, 32'h44332211, 4'hF);  // all valid 11..44
    add_frame(32'hB3B2B1B0, 4'hF,   32'h44FF2211, 4'b1011); // lane 2 invalid
    add_frame(32'h0,        4'h0,   32'hB3B2B1B0, 4'hF);  // back-to-back B frame
    add_frame(32'h0,        4'h0,   32'h0,        4'h0);  // all invalid

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].din, tbl[i].vin);
      @(posedge clk_4f);
      #1;
      edat = tbl[i].rst ? 8'h00 : (tbl[i].e_vld ? tbl[i].e_dat : FILL);
      chk($sformatf("tbl%0d.Salida", i),      int'(Salida),      int'(edat));
      chk($sformatf("tbl%0d.validSalida", i), int'(validSalida), int'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.frame_start", i), int'(frame_start), int'(tbl[i].e_fs));
      chk($sformatf("tbl%0d.phase", i),       int'(phase),       int'(tbl[i].e_ph));
    end

    // ---------------- reset pulsed after lane 1 of an A frame ----------------
    drive(1'b1, 32'h0, 4'h0);
    tick_model("rst_mid.r0");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'hA3A2A1A0, 4'hF);
      tick_model("rst_mid.load");
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 4'h0);
      tick_model("rst_mid.a01");
    end
    drive(1'b1, 32'h0, 4'h0);
    tick_model("rst_mid.pulse");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'hC3C2C1C0, 4'hF);
      tick_model("rst_mid.after");
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 4'h0);
      tick_model("rst_mid.cframe");
    end

    // ---------------- reset held 3 cycles, then invalid frames ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h5A5A5A5A, 4'hF);
      tick_model("rst3.hold");
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h12345678, 4'h0);
      tick_model("rst3.idle");
    end

    // ---------------- randomized run, inputs change every cycle ----------------
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) == 0), $urandom, 4'($urandom));
      tick_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
